// File: rtl/red_and_seq_if.sv
// Valid/ready bundle for red_and_seq: input vector handshake on one side,
// reduction result handshake plus status on the other.
interface red_and_seq_if #(
    parameter int width = 64,
    parameter int chunk = 8
);
    localparam int nchunks = (width + chunk - 1) / chunk;
    localparam int cw      = $clog2(nchunks + 1);

    logic [width-1:0] A;
    logic             in_valid;
    logic             in_ready;
    logic             Z;
    logic             out_valid;
    logic             out_ready;
    logic [cw-1:0]    chunks_used;
    logic             busy;

    modport master (
        output A, in_valid, out_ready,
        input  in_ready, Z, out_valid, chunks_used, busy
    );

    modport slave (
        input  A, in_valid, out_ready,
        output in_ready, Z, out_valid, chunks_used, busy
    );
endinterface

// File: rtl/red_and_seq.sv
// Chunk-serial AND reduction of a wide vector: one chunk-wide reduction per
// cycle, optional early exit on the first all-zero-AND chunk.
module red_and_seq #(
    parameter int width      = 64,
    parameter int chunk      = 8,
    parameter bit early_exit = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    red_and_seq_if.slave  bus
);
    localparam int nchunks = (width + chunk - 1) / chunk;
    localparam int cw      = $clog2(nchunks + 1);
    localparam int pw      = nchunks * chunk;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [pw-1:0]   vec_q;
    logic [pw-1:0]   padded;
    logic [cw-1:0]   idx_q;
    logic            acc_q;
    logic            z_q;
    logic [cw-1:0]   used_q;
    logic            r;
    logic            last;
    logic            exit_run;

    // Pad positions beyond width read as 1 so a partial last chunk never
    // pulls the result low.
    always_comb begin
        padded              = '1;
        padded[width-1:0]   = bus.A;
    end

    // The vector is shifted right each RUN cycle, so the chunk under
    // evaluation is always the bottom slice; no variable part-select needed.
    assign r        = &vec_q[chunk-1:0];
    assign last     = (idx_q == cw'(nchunks - 1));
    assign exit_run = last || (early_exit && !r);

    // NOTE: always_comb assigns every output a default first, so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (exit_run)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            z_q     <= 1'b0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec_q <= padded;
                        idx_q <= '0;
                        acc_q <= 1'b1;
                    end
                end
                RUN: begin
                    vec_q <= vec_q >> chunk;
                    idx_q <= idx_q + cw'(1);
                    acc_q <= acc_q & r;
                    if (exit_run) begin
                        z_q    <= acc_q & r;
                        used_q <= idx_q + cw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and status outputs decode state only, keeping in_valid and
    // out_ready off any combinational path to outputs.
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q == RUN);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.Z           = z_q;
    assign bus.chunks_used = used_q;

endmodule

// File: doc/red_and_seq.md
Name: red_and_seq

Overview:
- Sequential controller that AND-reduces a wide input vector in fixed-size chunks, one chunk per cycle, instead of as one wide combinational tree.
- Each cycle it feeds one chunk to an internal chunk-wide RedAnd reduction and accumulates the result.
- Supports early exit on the first zero chunk.
- Used where a full-width reduction would violate timing. Sits between a valid/ready producer and consumer.

Parameters:
width, 64, input vector width in bits (>=1)
chunk, 8, bits reduced per cycle (1..width)
early_exit, 1, 1 = stop at the first chunk whose AND is 0; 0 = always scan all chunks
nchunks (localparam), ceil(width/chunk), number of chunks
cw (localparam), clog2(nchunks+1), width of the chunk counter

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
A  input  width  vector to reduce, sampled on input handshake
in_valid  input  1  A is valid
in_ready  output  1  block can accept A
Z  output  1  reduction result, valid while out_valid=1
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
chunks_used  output  cw  number of chunks evaluated for the current result
busy  output  1  high in RUN state

Behaviour:
- Interface decision: one clock (clk_i); reset (rst_i) is synchronous and active-high. rst_i sampled at the clock edge overrides all other activity.
- Reset values: state=IDLE, in_ready=1, out_valid=0, Z=0, chunks_used=0, busy=0. Internal vector register and index cleared to 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register A into vec_q, set idx=0, acc=1, go to RUN.
  - RUN: busy=1, in_ready=0. Each cycle, reduce chunk vec_q[idx*chunk +: chunk] with the chunk-wide RedAnd, then set acc <= acc & r and idx <= idx+1.
  - RUN exits to DONE when idx==nchunks-1, or when early_exit=1 and r=0. On the exit cycle, Z <= acc & r and chunks_used <= idx+1.
  - DONE: out_valid=1; Z and chunks_used stay stable. On out_ready=1, go to IDLE and drop out_valid the next cycle.
- Partial last chunk (width not a multiple of chunk): the unused upper bit positions of the last chunk read as 1, so they never affect Z. No out-of-range index of vec_q.
- Latency: handshake at cycle T means RUN occupies T+1..T+k and out_valid rises at T+k+1.
  - k = nchunks normally.
  - With early exit, k = index of the first zero chunk + 1.
- Throughput: one vector per k+2 cycles at best. No input accepted in RUN or DONE; a new in_valid in DONE waits until IDLE.
- in_valid with in_ready=0 has no effect. A may change freely after the handshake.
- Backpressure: DONE holds indefinitely while out_ready=0, and outputs do not change.
- Reset mid-operation (RUN or DONE): return to reset values next cycle. The pending result is discarded and no out_valid pulse occurs.
- chunk==width: nchunks=1; every operation takes exactly one RUN cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. All outputs are registered or decoded from state only.

Test Plan:
- width=16, chunk=4, early_exit=1, A=0xFFFF -> RUN for 4 cycles, then out_valid=1, Z=1, chunks_used=4.
- Same config, A=0xFFEF (chunk1=0xE) -> early exit after 2 RUN cycles; Z=0, chunks_used=2.
- Same A with early_exit=0 -> 4 RUN cycles; Z=0, chunks_used=4.
- width=10, chunk=4:
  - A=0x3FF -> Z=1, chunks_used=3 (padding bits ignored).
  - A=0x1FF -> Z=0, chunks_used=3.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and a new A -> Z and chunks_used stable, in_ready=0. Release out_ready -> IDLE, then the new A is accepted on the next cycle.
- Reset: assert rst_i on the 2nd RUN cycle -> next cycle state IDLE, in_ready=1, out_valid=0, Z=0, chunks_used=0. Then A=0xFFFF completes normally with Z=1.
